// File: rtl/fp_score_feeder.sv
// fp_score_feeder: source side of the float max-index compare stream.
// Holds a DEPTH-entry table of IEEE-754 single-precision scores written by a
// host port. On go it streams entries 0..cnt-1, one per clock, as
// start/dataa/index_in into the compare block. CMP_LAT cycles after the last
// sample it captures the compare block's index_out as best_index and pulses done.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data table write port (IDLE only, addr >= DEPTH dropped)
//   go, count             start a stream of min(count, DEPTH) entries (IDLE only)
//   busy                  high while streaming or draining
//   start/dataa/index_in  sample stream to the compare block
//   index_out             running best index from the compare block
//   best_index, done      captured result and its one-cycle update pulse
module fp_score_feeder #(
  parameter int unsigned DEPTH   = 10,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CMP_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              go,
  input  logic [IDX_W:0]    count,
  output logic              busy,
  output logic              start,
  output logic [DATA_W-1:0] dataa,
  output logic [IDX_W-1:0]  index_in,
  input  logic [IDX_W-1:0]  index_out,
  output logic [IDX_W-1:0]  best_index,
  output logic              done
);

  localparam int unsigned CNT_W  = IDX_W + 1;
  // Drain counter runs CMP_LAT-1 down to 0.
  localparam int unsigned WAIT_W = (CMP_LAT > 1) ? $clog2(CMP_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    ptr, ptr_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_n;
  logic                busy_n, start_n, done_n;
  logic [DATA_W-1:0]   dataa_n;
  logic [IDX_W-1:0]    index_in_n, best_index_n;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                wr_ok_c;
  logic [DATA_W-1:0]   head_c;
  logic [CNT_W-1:0]    count_clamped_c;

  // Table writes are only taken while idle so a running stream sees a frozen table.
  assign wr_ok_c = wr_en && (state == S_IDLE) && (CNT_W'(wr_addr) < CNT_W'(DEPTH));

  // Sample 0 is launched in the same cycle as go, so forward a coincident write to entry 0.
  assign head_c = (wr_ok_c && (wr_addr == '0)) ? wr_data : mem[0];

  assign count_clamped_c = (count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count;

  // Score table; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next-state and next-output logic; stream outputs default to idle values.
  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    cnt_n        = cnt;
    wait_cnt_n   = wait_cnt;
    best_index_n = best_index;
    start_n      = 1'b0;
    dataa_n      = '0;
    index_in_n   = '0;
    done_n       = 1'b0;

    case (state)
      S_IDLE: begin
        if (go) begin
          if (count == '0) begin
            done_n       = 1'b1;
            best_index_n = '0;
          end else begin
            cnt_n      = count_clamped_c;
            start_n    = 1'b1;
            dataa_n    = head_c;
            index_in_n = '0;
            ptr_n      = CNT_W'(1);
            state_n    = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        // ptr is the next entry to launch; once it reaches cnt the stream is complete.
        if (ptr == cnt) begin
          wait_cnt_n = WAIT_W'(CMP_LAT - 1);
          ptr_n      = '0;
          state_n    = S_DRAIN;
        end else begin
          start_n    = 1'b1;
          dataa_n    = mem[IDX_W'(ptr)];
          index_in_n = IDX_W'(ptr);
          ptr_n      = ptr + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (wait_cnt == '0) begin
          best_index_n = index_out;
          done_n       = 1'b1;
          state_n      = S_IDLE;
        end else begin
          wait_cnt_n = wait_cnt - WAIT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n != S_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      wait_cnt   <= '0;
      busy       <= 1'b0;
      start      <= 1'b0;
      dataa      <= '0;
      index_in   <= '0;
      best_index <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      wait_cnt   <= wait_cnt_n;
      busy       <= busy_n;
      start      <= start_n;
      dataa      <= dataa_n;
      index_in   <= index_in_n;
      best_index <= best_index_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_fp_score_feeder.sv
// Directed self-checking bench for fp_score_feeder (DEPTH=10, IDX_W=4, CMP_LAT=1)
// with a small behavioural float arg-max compare block driving index_out.
module tb_fp_score_feeder;

  logic        clk;
  logic        reset_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        go;
  logic [4:0]  count;
  logic        busy;
  logic        start;
  logic [31:0] dataa;
  logic [3:0]  index_in;
  logic [3:0]  index_out;
  logic [3:0]  best_index;
  logic        done;

  int          checks;
  int          errors;
  logic [31:0] exp_mem [10];

  logic        rnd_phase;
  logic [3:0]  rnd_idx;
  logic        start_q;
  shortreal    best_v;
  logic [3:0]  model_idx;

  fp_score_feeder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .go         (go),
    .count      (count),
    .busy       (busy),
    .start      (start),
    .dataa      (dataa),
    .index_in   (index_in),
    .index_out  (index_out),
    .best_index (best_index),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare block model: arg-max over the current run, restarted on a start rising edge.
  always @(posedge clk) begin
    start_q <= start;
    if (start && (!start_q || ($bitstoshortreal(dataa) > best_v))) begin
      best_v    <= $bitstoshortreal(dataa);
      model_idx <= index_in;
    end
  end

  assign index_out = rnd_phase ? rnd_idx : model_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = data;
    tick();
    wr_en = 1'b0;
    exp_mem[addr] = data;
  endtask

  // Issue go, check every sample, the drain cycle and the done pulse.
  // inj >= 0 drives a write to entry 0 plus go during that sample cycle.
  task automatic run_stream(input string tag, input int req, input int n,
                            input int best, input int inj);
    go    = 1'b1;
    count = 5'(req);
    tick();
    go    = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_start"}, 32'(start), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_idx"}, 32'(index_in), 32'(i));
      check({tag, "_data"}, dataa, exp_mem[i]);
      if (i == inj) begin
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 32'hBF80_0000;
        go      = 1'b1;
        count   = 5'd3;
      end
      tick();
      wr_en = 1'b0;
      go    = 1'b0;
    end
    check({tag, "_drain_start"}, 32'(start), 32'd0);
    check({tag, "_drain_done"}, 32'(done), 32'd0);
    check({tag, "_drain_busy"}, 32'(busy), 32'd1);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_best"}, 32'(best_index), 32'(best));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_start"}, 32'(start), 32'd0);
    tick();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_start"}, 32'(start), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_dataa"}, dataa, 32'd0);
    check({tag, "_index_in"}, 32'(index_in), 32'd0);
    check({tag, "_best"}, 32'(best_index), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    go        = 1'b0;
    count     = '0;
    rnd_phase = 1'b1;
    rnd_idx   = '0;

    // Reset held with random inputs, then quiet idle after release.
    for (int c = 0; c < 4; c++) begin
      wr_en   = 1'($urandom);
      wr_addr = 4'($urandom);
      wr_data = $urandom;
      go      = 1'($urandom);
      count   = 5'($urandom);
      rnd_idx = 4'($urandom);
      tick();
      check_all_zero("rst");
    end
    wr_en     = 1'b0;
    go        = 1'b0;
    count     = '0;
    rnd_phase = 1'b0;
    reset_n   = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    check_all_zero("post_rst");

    // Load the full table; max of entries 0..2 is entry 1, max overall is entry 7.
    write_mem(0, 32'h3F80_0000);
    write_mem(1, 32'h4040_0000);
    write_mem(2, 32'h4020_0000);
    write_mem(3, 32'h3F00_0000);
    write_mem(4, 32'h4080_0000);
    write_mem(5, 32'h4000_0000);
    write_mem(6, 32'h3E80_0000);
    write_mem(7, 32'h4120_0000);
    write_mem(8, 32'h40E0_0000);
    write_mem(9, 32'h3F40_0000);
    // Out-of-range address must not disturb anything.
    wr_en = 1'b1; wr_addr = 4'd12; wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;

    run_stream("s3", 3, 3, 1, -1);

    // count = 0: immediate done with best_index 0, no samples.
    go = 1'b1; count = 5'd0;
    tick();
    go = 1'b0;
    check("c0_done", 32'(done), 32'd1);
    check("c0_best", 32'(best_index), 32'd0);
    check("c0_start", 32'(start), 32'd0);
    check("c0_busy", 32'(busy), 32'd0);
    tick();
    check("c0_done_pulse", 32'(done), 32'd0);
    check("c0_start2", 32'(start), 32'd0);

    // count above DEPTH is clamped to 10 samples.
    run_stream("s20", 20, 10, 7, -1);

    // Reset asserted during the second stream cycle.
    go = 1'b1; count = 5'd3;
    tick();
    go = 1'b0;
    check("mid_start1", 32'(start), 32'd1);
    tick();
    check("mid_start2", 32'(start), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    tick();
    check("mid_rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    tick();
    check("mid_rel_done", 32'(done), 32'd0);
    check("mid_rel_start", 32'(start), 32'd0);
    run_stream("after_rst", 2, 2, 1, -1);

    // Write and go during a stream are dropped; rerun still sees the old entry 0.
    run_stream("inj", 3, 3, 1, 1);
    run_stream("rerun", 1, 1, 0, -1);

    // Write to entry 0 coincident with go: the stream sees the new value.
    exp_mem[0] = 32'h4080_0000;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h4080_0000;
    run_stream("byp", 3, 3, 0, -1);

    // go held across done: restart right after done, gap of CMP_LAT+1 cycles.
    write_mem(2, 32'h4100_0000);
    go = 1'b1; count = 5'd3;
    tick();
    for (int c = 1; c <= 10; c++) begin
      automatic bit exp_start = ((c >= 1) && (c <= 3)) || ((c >= 6) && (c <= 8));
      automatic bit exp_done  = (c == 5) || (c == 10);
      check("b2b_start", 32'(start), 32'(exp_start));
      check("b2b_done", 32'(done), 32'(exp_done));
      if (exp_start) begin
        check("b2b_idx", 32'(index_in), 32'((c <= 3) ? (c - 1) : (c - 6)));
      end
      if (exp_done) begin
        check("b2b_best", 32'(best_index), 32'd2);
      end
      if (c == 6) go = 1'b0;
      tick();
    end
    check("b2b_end_start", 32'(start), 32'd0);
    check("b2b_end_done", 32'(done), 32'd0);
    check("b2b_end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
